idma_obi_cmd_issuer: RTL and testbench

Hardware OBI initiator that programs the tile iDMA through its memory-mapped control port, with no CPU involvement. It accepts one transfer command at a time over a valid/ready interface: direction, source, destination and length. It issues the register write/read sequence on the OBI control bus, then waits for the selected channel's done or error IRQ line. Finally it returns a completion record carrying the transfer ID. It sits beside the core as a second master on the iDMA control OBI crossbar port, and is used by tile-level sequencers such as event-driven prefetch.

---
 rtl/idma_obi_cmd_issuer.sv | 246 ++++++++++++++++++++++++
 tb/tb_idma_obi_cmd_issuer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_obi_cmd_issuer.sv
// idma_obi_cmd_issuer: OBI initiator that programs one iDMA channel
// (src/dst/len writes, next-ID read that launches the transfer), waits for
// that channel's done/error IRQ and returns a completion record.
// The small package below provides the default OBI request/response types.

package magia_tile_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } core_obi_a_chan_t;

  typedef struct packed {
    logic             req;
    core_obi_a_chan_t a;
  } core_obi_data_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } core_obi_r_chan_t;

  typedef struct packed {
    logic             gnt;
    logic             rvalid;
    core_obi_r_chan_t r;
  } core_obi_data_rsp_t;
endpackage

module idma_obi_cmd_issuer #(
  parameter type         obi_req_t   = magia_tile_pkg::core_obi_data_req_t,
  parameter type         obi_rsp_t   = magia_tile_pkg::core_obi_data_rsp_t,
  parameter logic [31:0] A2O_BASE    = 32'h0000_0000,
  parameter logic [31:0] O2A_BASE    = 32'h0000_0200,
  parameter logic [31:0] SRC_OFF     = 32'h00,
  parameter logic [31:0] DST_OFF     = 32'h04,
  parameter logic [31:0] LEN_OFF     = 32'h08,
  parameter logic [31:0] NEXT_ID_OFF = 32'h44
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_dir_i,
  input  logic [31:0] cmd_src_i,
  input  logic [31:0] cmd_dst_i,
  input  logic [31:0] cmd_len_i,
  output obi_req_t    obi_req_o,
  input  obi_rsp_t    obi_rsp_i,
  input  logic        irq_a2o_done_i,
  input  logic        irq_a2o_error_i,
  input  logic        irq_o2a_done_i,
  input  logic        irq_o2a_error_i,
  output logic        cpl_valid_o,
  input  logic        cpl_ready_i,
  output logic [31:0] cpl_id_o,
  output logic        cpl_error_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE, WR_SRC, WR_DST, WR_LEN, RD_ID, WAIT_DONE, CPL
  } state_t;

  state_t      state, state_next;
  // rsp_phase = 0: request held until gnt; 1: waiting for rvalid
  logic        rsp_phase, rsp_phase_next;
  logic        dir, dir_next;
  logic [31:0] base, base_next;
  logic [31:0] src, src_next;
  logic [31:0] dst, dst_next;
  logic [31:0] len, len_next;
  logic [31:0] id, id_next;
  logic        cpl_err, cpl_err_next;
  logic        done_cap, done_cap_next;
  logic        err_cap, err_cap_next;
  // a granted access was abandoned by clear_i; its rvalid is still owed
  logic        pending_rsp, pending_rsp_next;

  logic        bus_state;
  logic        armed;
  logic        sel_done, sel_err;
  logic        done_seen, err_seen;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Command, ID, capture and bookkeeping registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_phase   <= 1'b0;
      dir         <= 1'b0;
      base        <= '0;
      src         <= '0;
      dst         <= '0;
      len         <= '0;
      id          <= '0;
      cpl_err     <= 1'b0;
      done_cap    <= 1'b0;
      err_cap     <= 1'b0;
      pending_rsp <= 1'b0;
    end else begin
      rsp_phase   <= rsp_phase_next;
      dir         <= dir_next;
      base        <= base_next;
      src         <= src_next;
      dst         <= dst_next;
      len         <= len_next;
      id          <= id_next;
      cpl_err     <= cpl_err_next;
      done_cap    <= done_cap_next;
      err_cap     <= err_cap_next;
      pending_rsp <= pending_rsp_next;
    end
  end

  // Next-state, bus request and completion outputs
  always_comb begin
    state_next       = state;
    rsp_phase_next   = rsp_phase;
    dir_next         = dir;
    base_next        = base;
    src_next         = src;
    dst_next         = dst;
    len_next         = len;
    id_next          = id;
    cpl_err_next     = cpl_err;
    pending_rsp_next = pending_rsp & ~obi_rsp_i.rvalid;
    obi_req_o        = '0;

    cmd_ready_o = (state == IDLE) & ~pending_rsp;
    busy_o      = (state != IDLE);
    cpl_valid_o = (state == CPL);
    cpl_id_o    = (state == CPL) ? id : 32'h0;
    cpl_error_o = (state == CPL) & cpl_err;

    bus_state = (state == WR_SRC) || (state == WR_DST) ||
                (state == WR_LEN) || (state == RD_ID);

    // IRQ watching starts with the launch read's grant so that a transfer
    // that finishes before the ID comes back is still seen.
    armed     = ((state == RD_ID) && (rsp_phase || obi_rsp_i.gnt)) ||
                (state == WAIT_DONE);
    sel_done  = dir ? irq_o2a_done_i  : irq_a2o_done_i;
    sel_err   = dir ? irq_o2a_error_i : irq_a2o_error_i;
    done_seen = done_cap | (armed & sel_done);
    err_seen  = err_cap  | (armed & sel_err);
    done_cap_next = (state == IDLE) ? 1'b0 : done_seen;
    err_cap_next  = (state == IDLE) ? 1'b0 : err_seen;

    if (bus_state && !rsp_phase) begin
      obi_req_o.req  = 1'b1;
      obi_req_o.a.be = 4'hF;
      case (state)
        WR_SRC: begin
          obi_req_o.a.addr  = base + SRC_OFF;
          obi_req_o.a.we    = 1'b1;
          obi_req_o.a.wdata = src;
        end
        WR_DST: begin
          obi_req_o.a.addr  = base + DST_OFF;
          obi_req_o.a.we    = 1'b1;
          obi_req_o.a.wdata = dst;
        end
        WR_LEN: begin
          obi_req_o.a.addr  = base + LEN_OFF;
          obi_req_o.a.we    = 1'b1;
          obi_req_o.a.wdata = len;
        end
        default: begin
          obi_req_o.a.addr  = base + NEXT_ID_OFF;
          obi_req_o.a.we    = 1'b0;
        end
      endcase
    end

    case (state)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          dir_next       = cmd_dir_i;
          base_next      = cmd_dir_i ? O2A_BASE : A2O_BASE;
          src_next       = cmd_src_i;
          dst_next       = cmd_dst_i;
          len_next       = cmd_len_i;
          id_next        = 32'h0;
          cpl_err_next   = 1'b0;
          rsp_phase_next = 1'b0;
          state_next     = WR_SRC;
        end
      end
      WR_SRC, WR_DST, WR_LEN, RD_ID: begin
        if (!rsp_phase) begin
          if (obi_rsp_i.gnt) rsp_phase_next = 1'b1;
        end else if (obi_rsp_i.rvalid) begin
          rsp_phase_next = 1'b0;
          if (obi_rsp_i.r.err) begin
            // bus error: abandon the sequence, report with a null ID
            id_next      = 32'h0;
            cpl_err_next = 1'b1;
            state_next   = CPL;
          end else begin
            case (state)
              WR_SRC:  state_next = WR_DST;
              WR_DST:  state_next = WR_LEN;
              WR_LEN:  state_next = RD_ID;
              default: begin
                id_next    = obi_rsp_i.r.rdata;
                state_next = WAIT_DONE;
              end
            endcase
          end
        end
      end
      WAIT_DONE: begin
        if (done_seen || err_seen) begin
          cpl_err_next = err_seen;
          state_next   = CPL;
        end
      end
      CPL: begin
        if (cpl_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Soft clear wins over everything; an access already granted keeps
    // the block from taking new work until its response drains.
    if (clear_i) begin
      state_next     = IDLE;
      rsp_phase_next = 1'b0;
      if (bus_state && ((!rsp_phase && obi_rsp_i.gnt) ||
                        (rsp_phase && !obi_rsp_i.rvalid))) begin
        pending_rsp_next = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_idma_obi_cmd_issuer.sv
// Testbench for idma_obi_cmd_issuer: OBI slave responder with configurable
// grant stall, response latency and error injection, plus a reference model
// computing expected bus accesses, completion cycle, ID and error flag.
module tb_idma_obi_cmd_issuer;
  import magia_tile_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clear = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic               cmd_dir = 1'b0;
  logic [31:0]        cmd_src = '0;
  logic [31:0]        cmd_dst = '0;
  logic [31:0]        cmd_len = '0;
  core_obi_data_req_t obi_req;
  core_obi_data_rsp_t obi_rsp = '0;
  logic               irq_a2o_done = 1'b0;
  logic               irq_a2o_error = 1'b0;
  logic               irq_o2a_done = 1'b0;
  logic               irq_o2a_error = 1'b0;
  logic               cpl_valid;
  logic               cpl_ready = 1'b0;
  logic [31:0]        cpl_id;
  logic               cpl_error;
  logic               busy;

  idma_obi_cmd_issuer dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .clear_i         (clear),
    .cmd_valid_i     (cmd_valid),
    .cmd_ready_o     (cmd_ready),
    .cmd_dir_i       (cmd_dir),
    .cmd_src_i       (cmd_src),
    .cmd_dst_i       (cmd_dst),
    .cmd_len_i       (cmd_len),
    .obi_req_o       (obi_req),
    .obi_rsp_i       (obi_rsp),
    .irq_a2o_done_i  (irq_a2o_done),
    .irq_a2o_error_i (irq_a2o_error),
    .irq_o2a_done_i  (irq_o2a_done),
    .irq_o2a_error_i (irq_o2a_error),
    .cpl_valid_o     (cpl_valid),
    .cpl_ready_i     (cpl_ready),
    .cpl_id_o        (cpl_id),
    .cpl_error_o     (cpl_error),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // responder configuration
  int          gd = 0;        // grant stall cycles per request
  int          rd = 1;        // cycles from grant to rvalid
  int          err_idx = -1;  // index of access answered with err, -1 none
  logic [31:0] id_val = '0;   // rdata returned for the launch read

  core_obi_a_chan_t log_q[$];

  int               stall = 0;
  bit               rsp_pend = 0;
  int               rsp_cnt = 0;
  logic             rsp_err = 1'b0;
  logic [31:0]      rsp_data = '0;
  core_obi_a_chan_t held = '0;
  bit               holding = 0;

  // OBI slave: decisions taken on the falling edge, seen by DUT on rising edge
  always @(negedge clk) begin
    obi_rsp = '0;
    if (!rst_n) begin
      stall = 0; rsp_pend = 0; holding = 0;
    end else begin
      if (rsp_pend) begin
        if (rsp_cnt == 0) begin
          obi_rsp.rvalid  = 1'b1;
          obi_rsp.r.rdata = rsp_data;
          obi_rsp.r.err   = rsp_err;
          rsp_pend = 0;
        end else begin
          rsp_cnt--;
        end
      end
      if (obi_req.req) begin
        check("single_outstanding", {31'b0, rsp_pend}, 0);
        if (holding) check("req_stable", obi_req.a, held);
        held = obi_req.a;
        holding = 1;
        if (stall < gd) begin
          stall++;
        end else begin
          obi_rsp.gnt = 1'b1;
          stall = 0;
          holding = 0;
          log_q.push_back(obi_req.a);
          rsp_pend = 1;
          rsp_cnt  = rd - 1;
          rsp_err  = ((log_q.size() - 1) == err_idx);
          rsp_data = obi_req.a.we ? 32'h0 : id_val;
        end
      end else begin
        holding = 0;
      end
    end
  end

  function automatic logic [31:0] reg_off(input int i);
    case (i)
      0: return 32'h00;
      1: return 32'h04;
      2: return 32'h08;
      default: return 32'h44;
    endcase
  endfunction

  task automatic drive_irq(input logic dir, input bit hit, input int kind, input bit oth);
    irq_a2o_done  = dir ? oth  : (hit && kind != 1);
    irq_a2o_error = dir ? 1'b0 : (hit && kind != 0);
    irq_o2a_done  = dir ? (hit && kind != 1) : oth;
    irq_o2a_error = dir ? (hit && kind != 0) : 1'b0;
  endtask

  // present a command at a falling edge; the next rising edge is cycle 0
  task automatic start_cmd(input logic dir, input logic [31:0] src, input logic [31:0] dst,
                           input logic [31:0] len);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", {31'b0, cmd_ready}, 1);
    log_q.delete();
    cmd_dir = dir; cmd_src = src; cmd_dst = dst; cmd_len = len;
    cmd_valid = 1'b1;
  endtask

  // one full command; p = IRQ pulse cycle on the selected channel,
  // kind 0 done / 1 error / 2 both, oth = pulse cycle on the other channel
  task automatic run_cmd(input logic dir, input logic [31:0] src, input logic [31:0] dst,
                         input logic [31:0] len, input int p, input int kind,
                         input int oth, input int hold);
    int               per, ntx, w, exp_cpl, got;
    bit               bus_err, exp_err;
    logic [31:0]      base, exp_id, id0, wd;
    logic             err0;
    core_obi_a_chan_t a;
    per     = gd + 1 + rd;
    bus_err = (err_idx >= 0);
    ntx     = bus_err ? err_idx + 1 : 4;
    w       = 1 + 4 * per;
    exp_cpl = bus_err ? 1 + ntx * per : (((p > w) ? p : w) + 1);
    exp_id  = bus_err ? 32'h0 : id_val;
    exp_err = bus_err || (kind != 0);
    base    = dir ? 32'h200 : 32'h0;
    got = -1; id0 = '0; err0 = 1'b0;
    start_cmd(dir, src, dst, len);
    for (int k = 0; k < 400; k++) begin
      if (k == 1) cmd_valid = 1'b0;
      drive_irq(dir, k == p, kind, k == oth);
      if (got < 0 && cpl_valid) begin
        got = k; id0 = cpl_id; err0 = cpl_error;
      end else if (got >= 0 && k <= got + hold) begin
        check("cpl_hold", {cpl_valid, cpl_id, cpl_error}, {1'b1, id0, err0});
      end
      if (got >= 0 && k == got + hold) cpl_ready = 1'b1;
      if (got >= 0 && k == got + hold + 1) begin
        cpl_ready = 1'b0;
        check("cpl_drop", {31'b0, cpl_valid}, 0);
        check("ready_after_cpl", {31'b0, cmd_ready}, 1);
        break;
      end
      @(negedge clk);
    end
    drive_irq(dir, 0, 0, 0);
    cpl_ready = 1'b0;
    cmd_valid = 1'b0;
    check("cpl_cycle", got, exp_cpl);
    check("cpl_id", id0, exp_id);
    check("cpl_error", {31'b0, err0}, {31'b0, exp_err});
    check("txn_count", log_q.size(), ntx);
    for (int i = 0; i < ntx && i < log_q.size(); i++) begin
      a  = log_q[i];
      wd = (i == 0) ? src : (i == 1) ? dst : len;
      check("txn_addr", a.addr, base + reg_off(i));
      check("txn_we", {31'b0, a.we}, (i < 3) ? 1 : 0);
      check("txn_be", {28'b0, a.be}, 4'hF);
      if (i < 3) check("txn_wdata", a.wdata, wd);
    end
    $display("cmd dir=%0d gd=%0d rd=%0d err_idx=%0d cpl_cycle=%0d id=%0h err=%0d txns=%0d",
             dir, gd, rd, err_idx, got, id0, err0, log_q.size());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int   per, w, arm, p, kind, oth, hold;
    logic dirr;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, cmd_ready}, 1);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_cpl_valid", {31'b0, cpl_valid}, 0);
    check("rst_cpl_id", cpl_id, 0);
    check("rst_cpl_error", {31'b0, cpl_error}, 0);
    check("rst_obi_req", obi_req, 0);
    rst_n = 1'b1;

    // basic L2->L1 transfer, done at cycle 12
    gd = 0; rd = 1; err_idx = -1; id_val = 32'd7;
    run_cmd(1'b0, 32'h1000_0000, 32'h0000_0400, 32'd256, 12, 0, -1, 0);

    // direction select: a2o done at 10 must be ignored
    id_val = 32'h0000_00A5;
    run_cmd(1'b1, 32'h0000_0800, 32'h2000_0000, 32'd64, 14, 0, 10, 1);

    // early done between launch grant and its rvalid
    id_val = 32'h1234_5678;
    run_cmd(1'b1, 32'h0000_1000, 32'h3000_0000, 32'd32, 8, 0, -1, 0);

    // done and error in the same cycle
    id_val = 32'h0000_0042;
    run_cmd(1'b0, 32'h4000_0000, 32'h0000_2000, 32'd128, 10, 2, -1, 0);

    // bus error on the destination write
    err_idx = 1; id_val = 32'h0000_0099;
    run_cmd(1'b0, 32'h5000_0000, 32'h0000_3000, 32'd16, 10, 0, -1, 0);
    err_idx = -1;

    // grant stalls and completion backpressure
    gd = 3; id_val = 32'h0000_0BAD;
    run_cmd(1'b1, 32'h0000_4000, 32'h6000_0000, 32'd512, 21, 0, -1, 5);

    // randomized commands
    for (int t = 0; t < 8; t++) begin
      gd = int'($urandom_range(0, 3));
      rd = int'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) err_idx = int'($urandom_range(0, 3));
      else err_idx = -1;
      id_val = $urandom;
      dirr   = 1'($urandom_range(0, 1));
      per    = gd + 1 + rd;
      w      = 1 + 4 * per;
      arm    = w - 1 - rd;
      p      = int'($urandom_range(arm, w + 4));
      kind   = int'($urandom_range(0, 2));
      oth    = int'($urandom_range(1, w + 4));
      hold   = int'($urandom_range(0, 3));
      run_cmd(dirr, $urandom, $urandom, $urandom, p, kind, oth, hold);
    end
    err_idx = -1;

    // clear while the length write is granted but unanswered
    gd = 0; rd = 3; id_val = 32'h0000_0077;
    start_cmd(1'b0, 32'h7000_0000, 32'h0000_5000, 32'd8);
    for (int k = 0; k < 16; k++) begin
      if (k == 1) cmd_valid = 1'b0;
      clear = (k == 10);
      if (k == 11) begin
        check("clr_busy", {31'b0, busy}, 0);
        check("clr_ready_pending", {31'b0, cmd_ready}, 0);
        check("clr_req", {31'b0, obi_req.req}, 0);
      end
      if (k == 12) check("clr_ready_at_rvalid", {31'b0, cmd_ready}, 0);
      if (k == 13) check("clr_ready_after", {31'b0, cmd_ready}, 1);
      @(negedge clk);
    end
    clear = 1'b0;
    check("clr_txn_count", log_q.size(), 3);
    $display("cmd clear test txns=%0d", log_q.size());

    // asynchronous reset while waiting for done
    gd = 0; rd = 1; id_val = 32'h0000_0055;
    start_cmd(1'b1, 32'h0000_6000, 32'h8000_0000, 32'd4);
    for (int k = 0; k < 11; k++) begin
      if (k == 1) cmd_valid = 1'b0;
      @(negedge clk);
    end
    check("wait_busy", {31'b0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("arst_ready", {31'b0, cmd_ready}, 1);
    check("arst_busy", {31'b0, busy}, 0);
    check("arst_cpl_valid", {31'b0, cpl_valid}, 0);
    check("arst_cpl_id", cpl_id, 0);
    check("arst_cpl_error", {31'b0, cpl_error}, 0);
    check("arst_obi_req", obi_req, 0);
    $display("cmd reset test");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // recovery after reset
    id_val = 32'h0000_0101;
    run_cmd(1'b0, 32'h0000_7000, 32'h9000_0000, 32'd1024, 9, 1, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
